// File: rtl/bus_pkg.sv
// Shared bus widths and scheduler state encoding.
package bus_pkg;

  localparam int unsigned BUS_ADDR_W = 32;
  localparam int unsigned BUS_DATA_W = 32;
  localparam int unsigned BUS_MASK_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } sched_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester after `last`, wrapping.
module rr_picker #(
  parameter int unsigned NUM_MASTERS = 3,
  parameter int unsigned IDX_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic [NUM_MASTERS-1:0] req_in,
  input  logic [IDX_W-1:0]       last_in,
  output logic                   valid_out,
  output logic [IDX_W-1:0]       index_out
);

  int unsigned cand;

  // Scan last+1 .. last+NUM_MASTERS modulo NUM_MASTERS; lowest offset wins.
  always_comb begin
    valid_out = 1'b0;
    index_out = '0;
    cand      = 0;
    for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
      cand = (32'(last_in) + k) % NUM_MASTERS;
      if (!valid_out && req_in[IDX_W'(cand)]) begin
        valid_out = 1'b1;
        index_out = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/bus_scheduler.sv
// Round-robin arbiter sharing the single memory bus, with slave timeout fault.
module bus_scheduler
  import bus_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 3,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [BUS_ADDR_W*NUM_MASTERS-1:0] m_address_in,
  input  logic [NUM_MASTERS-1:0]            m_read_in,
  input  logic [NUM_MASTERS-1:0]            m_write_in,
  input  logic [BUS_MASK_W*NUM_MASTERS-1:0] m_write_mask_in,
  input  logic [BUS_DATA_W*NUM_MASTERS-1:0] m_write_value_in,
  output logic [BUS_DATA_W*NUM_MASTERS-1:0] m_read_value_out,
  output logic [NUM_MASTERS-1:0]            m_ready_out,
  output logic [NUM_MASTERS-1:0]            m_fault_out,
  output logic [BUS_ADDR_W-1:0]             address_out,
  output logic                              read_out,
  output logic                              write_out,
  output logic [BUS_MASK_W-1:0]             write_mask_out,
  output logic [BUS_DATA_W-1:0]             write_value_out,
  input  logic [BUS_DATA_W-1:0]             read_value_in,
  input  logic                              ready_in,
  input  logic                              fault_in,
  output logic                              busy_out
);

  localparam int unsigned IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  sched_state_t            state_q, state_d;
  logic [IDX_W-1:0]        grant_q, grant_d;
  logic [IDX_W-1:0]        last_q, last_d;
  logic [CNT_W-1:0]        tcount_q, tcount_d;

  logic [NUM_MASTERS-1:0]  req;
  logic                    pick_valid;
  logic [IDX_W-1:0]        pick_index;
  logic [NUM_MASTERS-1:0]  grant_oh;
  logic                    timeout;

  assign req     = m_read_in | m_write_in;
  assign timeout = (tcount_q == CNT_W'(TIMEOUT_CYCLES - 1));

  rr_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IDX_W)
  ) u_picker (
    .req_in    (req),
    .last_in   (last_q),
    .valid_out (pick_valid),
    .index_out (pick_index)
  );

  // State and bookkeeping registers; last starts at the top index so master 0 wins first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      last_q   <= IDX_W'(NUM_MASTERS - 1);
      tcount_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      tcount_q <= tcount_d;
    end
  end

  // Next-state and bus routing; all outputs quiet outside BUSY.
  always_comb begin
    state_d          = state_q;
    grant_d          = grant_q;
    last_d           = last_q;
    tcount_d         = tcount_q;
    grant_oh         = '0;
    address_out      = '0;
    read_out         = 1'b0;
    write_out        = 1'b0;
    write_mask_out   = '0;
    write_value_out  = '0;
    m_read_value_out = '0;
    m_ready_out      = '0;
    m_fault_out      = '0;
    busy_out         = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d  = pick_index;
          last_d   = pick_index;
          tcount_d = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        busy_out = 1'b1;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
          if (IDX_W'(i) == grant_q) begin
            grant_oh[i]     = 1'b1;
            address_out     = m_address_in[i*BUS_ADDR_W +: BUS_ADDR_W];
            read_out        = m_read_in[i];
            write_out       = m_write_in[i];
            write_mask_out  = m_write_mask_in[i*BUS_MASK_W +: BUS_MASK_W];
            write_value_out = m_write_value_in[i*BUS_DATA_W +: BUS_DATA_W];
            m_read_value_out[i*BUS_DATA_W +: BUS_DATA_W] = read_value_in;
          end
        end
        if (ready_in) begin
          m_ready_out = grant_oh;
          m_fault_out = fault_in ? grant_oh : '0;
          state_d     = IDLE;
        end else if (timeout) begin
          // Silent slave: withdraw the strobes and report a fault to the master.
          read_out         = 1'b0;
          write_out        = 1'b0;
          write_mask_out   = '0;
          m_read_value_out = '0;
          m_ready_out      = grant_oh;
          m_fault_out      = grant_oh;
          state_d          = IDLE;
        end else begin
          tcount_d = tcount_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
